// File: rtl/io_bus_sequencer_pkg.sv
// io_bus_sequencer_pkg
//   Shared definitions for the I/O bus sequencer: the FSM state encoding, the
//   shape of a captured request, and the widths of the wait/timeout counter.
//   There are no ports. The types are imported by io_bus_sequencer and
//   io_bus_sequencer_wait_ctr.
package io_bus_sequencer_pkg;

    // WAIT_STATES fits in 4 bits and TIMEOUT fits in 8 bits. A single counter
    // of the wider width serves both.
    localparam int unsigned WaitWidth = 4;
    localparam int unsigned CtrWidth  = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StSetup  = 3'd2,
        StStrobe = 3'd3,
        StHold   = 3'd4,
        StErr    = 3'd5
    } seq_state_e;

    // Request fields are latched at acceptance and held for the whole cycle.
    typedef struct packed {
        logic is_write;
        logic is_word;
        logic is_dev;
    } io_req_t;

endpackage

// File: rtl/io_bus_sequencer_wait_ctr.sv
// io_bus_sequencer_wait_ctr
//   A loadable down-counter that saturates at zero. The sequencer uses it
//   first to count the strobe wait states and then to count the dev_wait
//   timeout.
// Ports
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset (the count goes to 0)
//   load        in   load load_value (takes priority over dec)
//   load_value  in   value to load
//   dec         in   decrement by one, holding at zero
//   zero        out  the current count is zero
//   zero_next   out  the count after the coming edge will be zero
module io_bus_sequencer_wait_ctr
    import io_bus_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [CtrWidth-1:0] load_value,
    input  logic                dec,
    output logic                zero,
    output logic                zero_next
);

    logic [CtrWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero      = (count_q == '0);
    assign zero_next = (count_d == '0);

endmodule

// File: rtl/io_bus_sequencer.sv
// io_bus_sequencer
//   Turns one CPU I/O request into the timed control sequence that
//   io_interface consumes: IDLE -> LOAD -> SETUP -> STROBE(xN) -> HOLD.
//   An unaligned word access goes to ERR instead and never touches the bus.
//   Every output except ready is registered. Each output register is loaded
//   from the value decoded for the next state, so the outputs line up with the
//   state they describe.
// Parameters
//   WAIT_STATES  extra STROBE cycles beyond the first (0..15)
//   TIMEOUT      max extra STROBE cycles while dev_wait is held (1..255)
// Configuration macro
//   IO_SEQ_WAIT_EN  when defined, adds the dev_wait input. dev_wait passes a
//                   2-flop synchronizer, and STROBE stretches while the
//                   synchronized dev_wait is high. If the stretch runs past
//                   TIMEOUT extra cycles, the cycle ends with done and error.
// Ports
//   clock, reset                   clock; asynchronous active-high reset
//   req_valid                      request present, accepted when ready
//   req_write/word/dev/addr0       request attributes (write, 16-bit, device space, a_bus bit 0)
//   dev_wait                       external stretch request (IO_SEQ_WAIT_EN only)
//   ready                          the sequencer is idle
//   done, error                    1-cycle completion pulse, and error qualifier
//   rdata_capture                  read data on y_bus is valid this cycle
//   address_ld_n, data_ld_n        active-low latch enables to io_interface
//   idle_n, dir_out, word          bus-cycle qualifiers to io_interface
//   select_dev                     bus-cycle qualifier to io_interface
//   rd, wr                         active-high strobes to io_interface
module io_bus_sequencer
    import io_bus_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    input  logic req_write,
    input  logic req_word,
    input  logic req_dev,
    input  logic req_addr0,
`ifdef IO_SEQ_WAIT_EN
    input  logic dev_wait,
`endif
    output logic ready,
    output logic done,
    output logic error,
    output logic rdata_capture,
    output logic address_ld_n,
    output logic data_ld_n,
    output logic idle_n,
    output logic dir_out,
    output logic word,
    output logic select_dev,
    output logic rd,
    output logic wr
);

    seq_state_e state_q, state_d;
    io_req_t    req_q, req_d;
    // Set once the minimum strobe has been served and STROBE is being stretched.
    logic       ext_q, ext_d;
    logic       timeout;

    logic                ctr_load, ctr_dec, ctr_zero, ctr_zero_next;
    logic [CtrWidth-1:0] ctr_load_value;

    // dev_sync is the synchronized dev_wait for the current cycle.
    // dev_sync_next is the value dev_sync will take in the following cycle.
    logic dev_sync, dev_sync_next;

    logic done_q, error_q, rdata_capture_q, address_ld_n_q, data_ld_n_q;
    logic idle_n_q, dir_out_q, word_q, select_dev_q, rd_q, wr_q;
    logic done_d, error_d, rdata_capture_d, address_ld_n_d, data_ld_n_d;
    logic idle_n_d, dir_out_d, word_d, select_dev_d, rd_d, wr_d;
    logic bus_active_d;

`ifdef IO_SEQ_WAIT_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= dev_wait;
            sync2_q <= sync1_q;
        end
    end

    assign dev_sync      = sync2_q;
    assign dev_sync_next = sync1_q;
`else
    assign dev_sync      = 1'b0;
    assign dev_sync_next = 1'b0;
`endif

    io_bus_sequencer_wait_ctr u_wait_ctr (
        .clock      (clock),
        .reset      (reset),
        .load       (ctr_load),
        .load_value (ctr_load_value),
        .dec        (ctr_dec),
        .zero       (ctr_zero),
        .zero_next  (ctr_zero_next)
    );

    // Next-state logic and counter control
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        ext_d          = ext_q;
        timeout        = 1'b0;
        ctr_load       = 1'b0;
        ctr_dec        = 1'b0;
        ctr_load_value = CtrWidth'(WaitWidth'(WAIT_STATES));

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d.is_write = req_write;
                    req_d.is_word  = req_word;
                    req_d.is_dev   = req_dev;
                    state_d        = (req_word && req_addr0) ? StErr : StLoad;
                end
            end
            StErr:   state_d = StIdle;
            StLoad:  state_d = StSetup;
            StSetup: begin
                state_d  = StStrobe;
                ctr_load = 1'b1;
                ext_d    = 1'b0;
            end
            StStrobe: begin
                if (!ext_q && !ctr_zero) begin
                    ctr_dec = 1'b1;
                end else if (!dev_sync) begin
                    state_d = StHold;
                end else if (!ext_q) begin
                    // Switch the counter over to the timeout budget. A count of
                    // TIMEOUT-1 allows exactly TIMEOUT extra cycles.
                    ext_d          = 1'b1;
                    ctr_load       = 1'b1;
                    ctr_load_value = CtrWidth'(TIMEOUT - 1);
                end else if (ctr_zero) begin
                    state_d = StHold;
                    timeout = 1'b1;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output values for the cycle that begins at the coming edge
    always_comb begin
        bus_active_d    = (state_d == StLoad) || (state_d == StSetup) ||
                          (state_d == StStrobe) || (state_d == StHold);
        address_ld_n_d  = (state_d != StLoad);
        data_ld_n_d     = !((state_d == StLoad) && req_d.is_write);
        idle_n_d        = bus_active_d;
        dir_out_d       = bus_active_d && req_d.is_write;
        word_d          = bus_active_d && req_d.is_word;
        select_dev_d    = bus_active_d && req_d.is_dev;
        rd_d            = (state_d == StStrobe) && !req_d.is_write;
        wr_d            = (state_d == StStrobe) && req_d.is_write;
        // y_bus is valid on the strobe cycle that ends the read. That is the
        // first cycle after the minimum strobe in which dev_wait is seen low.
        rdata_capture_d = rd_d && (ext_d || ctr_zero_next) && !dev_sync_next;
        done_d          = (state_d == StHold) || (state_d == StErr);
        error_d         = (state_d == StErr) || timeout;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            req_q           <= '0;
            ext_q           <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            rdata_capture_q <= 1'b0;
            address_ld_n_q  <= 1'b1;
            data_ld_n_q     <= 1'b1;
            idle_n_q        <= 1'b0;
            dir_out_q       <= 1'b0;
            word_q          <= 1'b0;
            select_dev_q    <= 1'b0;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            ext_q           <= ext_d;
            done_q          <= done_d;
            error_q         <= error_d;
            rdata_capture_q <= rdata_capture_d;
            address_ld_n_q  <= address_ld_n_d;
            data_ld_n_q     <= data_ld_n_d;
            idle_n_q        <= idle_n_d;
            dir_out_q       <= dir_out_d;
            word_q          <= word_d;
            select_dev_q    <= select_dev_d;
            rd_q            <= rd_d;
            wr_q            <= wr_d;
        end
    end

    assign ready         = (state_q == StIdle);
    assign done          = done_q;
    assign error         = error_q;
    assign rdata_capture = rdata_capture_q;
    assign address_ld_n  = address_ld_n_q;
    assign data_ld_n     = data_ld_n_q;
    assign idle_n        = idle_n_q;
    assign dir_out       = dir_out_q;
    assign word          = word_q;
    assign select_dev    = select_dev_q;
    assign rd            = rd_q;
    assign wr            = wr_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// tb_io_bus_sequencer
//   Self-checking bench for io_bus_sequencer. After every clock edge, the
//   bench compares the complete output vector with a cycle-level reference
//   model. The model tracks the number of cycles since a request was accepted,
//   the number of stretch cycles, and the synchronized dev_wait history.
//   Directed scenarios come first, followed by randomized traffic with
//   occasional resets. The dev_wait scenarios are built when IO_SEQ_WAIT_EN
//   is defined.
module tb_io_bus_sequencer;

    localparam int WS = 1;
    localparam int TO = 3;

    logic clock, reset;
    logic req_valid, req_write, req_word, req_dev, req_addr0, dev_wait;
    logic ready, done, error, rdata_capture, address_ld_n, data_ld_n;
    logic idle_n, dir_out, word, select_dev, rd, wr;

    int checks = 0;
    int errors = 0;

    io_bus_sequencer #(
        .WAIT_STATES (WS),
        .TIMEOUT     (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_word      (req_word),
        .req_dev       (req_dev),
        .req_addr0     (req_addr0),
`ifdef IO_SEQ_WAIT_EN
        .dev_wait      (dev_wait),
`endif
        .ready         (ready),
        .done          (done),
        .error         (error),
        .rdata_capture (rdata_capture),
        .address_ld_n  (address_ld_n),
        .data_ld_n     (data_ld_n),
        .idle_n        (idle_n),
        .dir_out       (dir_out),
        .word          (word),
        .select_dev    (select_dev),
        .rd            (rd),
        .wr            (wr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    bit m_busy, m_err, m_hold, m_to, m_acc;
    bit m_w, m_wd, m_dv;
    int m_t;      // cycles since acceptance, 1 = address load cycle
    int m_extra;  // strobe cycles added beyond the minimum
    bit s1, s2;   // dev_wait as seen 1 and 2 edges later

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_hold = 0; m_to = 0; m_acc = 0;
        m_t = 0; m_extra = 0; s1 = 0; s2 = 0;
    endtask

    // Advances the model across one clock edge, using the inputs present now.
    task automatic model_edge();
        m_acc = 0;
        if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_acc = 1; m_err = req_word && req_addr0;
                m_w = req_write; m_wd = req_word; m_dv = req_dev;
                m_t = 1; m_extra = 0; m_hold = 0; m_to = 0;
            end
        end else if (m_err || m_hold) begin
            m_busy = 0; m_err = 0; m_hold = 0;
        end else if (m_t >= WS + 3) begin
            if (!s2 || m_extra == TO) begin
                m_hold = 1; m_to = s2;
            end else begin
                m_extra++; m_t++;
            end
        end else begin
            m_t++;
        end
        s2 = s1;
        s1 = dev_wait;
    endtask

    function automatic logic [11:0] model_out();
        logic dn, er, rc, aln, dln, idn, dr, wd, sd, r, w;
        dn = 0; er = 0; rc = 0; aln = 1; dln = 1; idn = 0;
        dr = 0; wd = 0; sd = 0; r = 0; w = 0;
        if (m_busy && m_err) begin
            dn = 1; er = 1;
        end else if (m_busy) begin
            idn = 1; dr = m_w; wd = m_wd; sd = m_dv;
            if (m_hold) begin
                dn = 1; er = m_to;
            end else if (m_t == 1) begin
                aln = 0; dln = !m_w;
            end else if (m_t >= 3) begin
                r = !m_w; w = m_w;
                rc = !m_w && (m_t >= WS + 3) && !s2;
            end
        end
        return {!m_busy, dn, er, rc, aln, dln, idn, dr, wd, sd, r, w};
    endfunction

    task automatic check_vec(input string tag);
        logic [11:0] obs, exp;
        obs = {ready, done, error, rdata_capture, address_ld_n, data_ld_n,
               idle_n, dir_out, word, select_dev, rd, wr};
        exp = model_out();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (rdy,dn,er,rc,aln,dln,idn,dir,wd,sel,rd,wr)",
                   tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_vec(tag);
    endtask

    // Asynchronous reset pulse in the middle of a cycle. The outputs must be
    // inactive before the next edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_vec(tag);
        reset = 1'b0;
    endtask

    // Issues one request from idle and measures the cycles from acceptance to
    // done. drop_at > 0 raises dev_wait before the accept edge and drops it
    // after that cycle number has been observed.
    task automatic run_req(input bit w, input bit wd, input bit dv, input bit a0,
                           input int drop_at, input int exp_lat, input bit exp_err,
                           input string tag);
        int lat;
        req_write = w; req_word = wd; req_dev = dv; req_addr0 = a0; req_valid = 1'b1;
        if (drop_at > 0) dev_wait = 1'b1;
        step({tag, " accept"});
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == drop_at) dev_wait = 1'b0;
            step(tag);
            lat++;
        end
        check_int({tag, " latency"}, lat, exp_lat);
        check_int({tag, " error"}, int'(error), int'(exp_err));
        dev_wait = 1'b0;
        step({tag, " return"});
    endtask

    initial begin
        int gap, n;
        reset = 1'b1; req_valid = 0; req_write = 0; req_word = 0;
        req_dev = 0; req_addr0 = 0; dev_wait = 0;
        model_reset();
        @(posedge clock); #1;
        check_vec("reset");
        @(posedge clock); #1;
        check_vec("reset held");
        reset = 1'b0;
        step("idle");
        step("idle");

        // Directed requests: (write, word, dev, addr0)
        run_req(0, 0, 0, 0, 0, WS + 4, 0, "byte read mem");
        run_req(1, 1, 0, 0, 0, WS + 4, 0, "word write");
        run_req(0, 1, 0, 1, 0, 1, 1, "unaligned word read");
        run_req(1, 0, 1, 1, 0, WS + 4, 0, "byte write dev odd");
        run_req(1, 1, 1, 1, 0, 1, 1, "unaligned word write");
        run_req(0, 1, 1, 0, 0, WS + 4, 0, "word read dev");

        // Reset during STROBE aborts without done
        req_write = 0; req_word = 0; req_dev = 1; req_addr0 = 0; req_valid = 1'b1;
        step("abort accept");
        req_valid = 1'b0;
        step("abort setup");
        step("abort strobe");
        reset_pulse("reset in strobe");
        step("after reset");
        step("after reset");
        run_req(0, 0, 1, 0, 0, WS + 4, 0, "read after reset");

        // Back-to-back: req_valid held across two requests
        req_write = 1; req_word = 0; req_dev = 0; req_addr0 = 0; req_valid = 1'b1;
        step("b2b accept");
        n = 1;
        while (!done && n < 40) begin step("b2b first"); n++; end
        check_int("b2b first latency", n, WS + 4);
        gap = 0;
        while (address_ld_n && gap < 40) begin step("b2b gap"); gap++; end
        check_int("b2b done to second load", gap, 2);
        req_valid = 1'b0;
        n = 0;
        while (!ready && n < 40) begin step("b2b drain"); n++; end
        check_int("b2b drained", int'(ready), 1);

`ifdef IO_SEQ_WAIT_EN
        run_req(0, 0, 1, 0, WS + 3, WS + 4 + 2, 0, "stretch 2");
        run_req(0, 0, 1, 0, 99, WS + 4 + TO, 1, "stretch timeout");
        run_req(1, 1, 1, 0, 99, WS + 4 + TO, 1, "write timeout");
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step("random");
            if ($urandom_range(0, 249) == 0) reset_pulse("random reset");
            if (req_valid && m_acc) begin
                if ($urandom_range(0, 1) == 0) begin
                    req_valid = 1'b0;
                end else begin
                    {req_write, req_word, req_dev, req_addr0} = 4'($urandom);
                end
            end else if (!req_valid && $urandom_range(0, 2) == 0) begin
                {req_write, req_word, req_dev, req_addr0} = 4'($urandom);
                req_valid = 1'b1;
            end
`ifdef IO_SEQ_WAIT_EN
            if ($urandom_range(0, 4) == 0) dev_wait = !dev_wait;
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
